// File: rtl/reduction_sequencer_pkg.sv
// Shared types and constants for the decision-stage reduction sequencer.
package decision_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    DRAIN,
    ARGMAX,
    RESULT
  } state_t;

  localparam int N_MATS_DEF     = 10;
  localparam int DATA_WIDTH_DEF = 16;

  // Class index width, at least one bit even for a single class.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reduction_sequencer_argmax.sv
// Serial signed argmax: one lane compared per cycle, ties keep the lower index.
module argmax_serial
  import decision_pkg::*;
#(
  parameter int N          = N_MATS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [N-1:0][DATA_WIDTH-1:0]     values,
  output logic                             done,
  output logic [idx_width(N)-1:0]          best_idx,
  output logic [DATA_WIDTH-1:0]            best_val
);

  localparam int IDX_W = idx_width(N);

  logic [IDX_W-1:0] ptr;
  logic             running;

  // done is asserted during the cycle in which the final lane is compared.
  assign done = running && (ptr == IDX_W'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      running  <= 1'b0;
      best_idx <= '0;
      best_val <= '0;
    end else if (start) begin
      best_idx <= '0;
      best_val <= values[0];
      ptr      <= (N > 1) ? IDX_W'(1) : '0;
      running  <= (N > 1);
    end else if (running) begin
      if ($signed(values[ptr]) > $signed(best_val)) begin
        best_idx <= ptr;
        best_val <= values[ptr];
      end
      if (ptr == IDX_W'(N - 1)) begin
        running <= 1'b0;
      end else begin
        ptr <= ptr + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/reduction_sequencer.sv
// Feeds frame columns to the reducer array, gathers per-class sums and reports the argmax.
// Optional DRAIN timeout enabled by defining REDUCTION_WATCHDOG_EN.
module reduction_sequencer
  import decision_pkg::*;
#(
  parameter int N_MATS     = N_MATS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_COLS     = 2
`ifdef REDUCTION_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = 64
`endif
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  col_valid,
  output logic                                  col_ready,
  input  logic [N_MATS-1:0][1:0][DATA_WIDTH-1:0] col_data,
  output logic                                  red_valid_in,
  output logic [N_MATS-1:0][1:0][DATA_WIDTH-1:0] red_column,
  input  logic [N_MATS-1:0]                     red_valid_out,
  input  logic [N_MATS-1:0][DATA_WIDTH-1:0]     red_sum,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic [idx_width(N_MATS)-1:0]          class_idx,
  output logic [DATA_WIDTH-1:0]                 class_score,
  output logic                                  busy,
  output logic                                  wdog_err
);

  localparam int CNT_W = $clog2(N_COLS + 1);

  state_t state, state_nxt;

  logic [CNT_W-1:0]                  col_cnt;
  logic [N_MATS-1:0][DATA_WIDTH-1:0] sum_q;
  logic [N_MATS-1:0]                 mask_q;
  logic col_accept, last_col, mask_full, capture_en;
  logic frame_start, result_take, argmax_start, argmax_done, wdog_fire;

  assign col_ready    = (state == FEED);
  assign col_accept   = col_valid && col_ready;
  assign last_col     = (col_cnt == CNT_W'(N_COLS - 1));
  assign mask_full    = &mask_q;
  assign capture_en   = (state == FEED) || (state == DRAIN);
  assign frame_start  = (state == IDLE) && start;
  assign result_valid = (state == RESULT);
  assign result_take  = result_valid && result_ready;
  assign busy         = (state != IDLE);
  assign argmax_start = (state == DRAIN) && mask_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FEED;
      FEED:    if (col_accept && last_col) state_nxt = DRAIN;
      DRAIN: begin
        if (mask_full) begin
          state_nxt = (N_MATS > 1) ? ARGMAX : RESULT;
        end else if (wdog_fire) begin
          state_nxt = IDLE;
        end
      end
      ARGMAX:  if (argmax_done) state_nxt = RESULT;
      RESULT:  if (result_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Column register stage: one strobe per accepted column, one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt      <= '0;
      red_column   <= '0;
      red_valid_in <= 1'b0;
    end else begin
      red_valid_in <= col_accept;
      if (frame_start) begin
        col_cnt <= '0;
      end else if (col_accept) begin
        col_cnt    <= col_cnt + CNT_W'(1);
        red_column <= col_data;
      end
    end
  end

  // Lane sums may arrive early (during FEED) and later pulses overwrite earlier ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q  <= '0;
      mask_q <= '0;
    end else if (frame_start || result_take) begin
      mask_q <= '0;
    end else if (capture_en) begin
      for (int i = 0; i < N_MATS; i++) begin
        if (red_valid_out[i]) begin
          sum_q[i]  <= red_sum[i];
          mask_q[i] <= 1'b1;
        end
      end
    end
  end

  argmax_serial #(
    .N          (N_MATS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .start    (argmax_start),
    .values   (sum_q),
    .done     (argmax_done),
    .best_idx (class_idx),
    .best_val (class_score)
  );

`ifdef REDUCTION_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wdog_cnt;
  logic            wdog_q;

  assign wdog_fire = (state == DRAIN) && !mask_full && (wdog_cnt == WD_W'(WDOG_CYCLES - 1));
  assign wdog_err  = wdog_q;

  // Counter only advances while draining, so it restarts from zero on every DRAIN entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt <= '0;
      wdog_q   <= 1'b0;
    end else begin
      wdog_cnt <= (state == DRAIN) ? wdog_cnt + WD_W'(1) : '0;
      if (wdog_fire) begin
        wdog_q <= 1'b1;
      end
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign wdog_err  = 1'b0;
`endif

endmodule

// File: tb/tb_reduction_sequencer.sv
// Directed bench for reduction_sequencer: cycle table for a nominal frame plus corner sequences.
module tb_reduction_sequencer;

  localparam int N_MATS = 10;
  localparam int DW     = 16;
  localparam int N_COLS = 2;
  localparam int IW     = 4;

  typedef logic [N_MATS-1:0][1:0][DW-1:0] col_t;
  typedef logic [N_MATS-1:0][DW-1:0]      sum_t;

  typedef struct {
    logic              start;
    logic              col_valid;
    int                col_seed;
    logic [N_MATS-1:0] rvo;
    logic              rr;
    logic              e_ready;
    logic              e_rvi;
    logic              e_rv;
    logic              e_busy;
    int                e_col;
    int                e_idx;
    logic [DW-1:0]     e_score;
  } vec_t;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, col_valid = 1'b0, result_ready = 1'b0;
  col_t col_data = '0;
  sum_t red_sum = '0;
  logic [N_MATS-1:0] red_valid_out = '0;

  logic col_ready, red_valid_in, result_valid, busy, wdog_err;
  col_t red_column;
  logic [IW-1:0] class_idx;
  logic [DW-1:0] class_score;

  int checks = 0, errors = 0, rvi_count = 0, cycles = 0;
  logic rv_seen = 1'b0;
  int nominal_sums[N_MATS] = '{3, -1, 7, 2, 0, 5, 7, -4, 1, 6};
  vec_t vecs[$];

  reduction_sequencer #(
    .N_MATS     (N_MATS),
    .DATA_WIDTH (DW),
    .N_COLS     (N_COLS)
`ifdef REDUCTION_WATCHDOG_EN
    ,
    .WDOG_CYCLES(8)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .col_valid     (col_valid),
    .col_ready     (col_ready),
    .col_data      (col_data),
    .red_valid_in  (red_valid_in),
    .red_column    (red_column),
    .red_valid_out (red_valid_out),
    .red_sum       (red_sum),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .class_idx     (class_idx),
    .class_score   (class_score),
    .busy          (busy),
    .wdog_err      (wdog_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (red_valid_in) rvi_count++;
    if (result_valid) rv_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  function automatic col_t col_pattern(input int seed);
    col_t c;
    for (int i = 0; i < N_MATS; i++)
      for (int j = 0; j < 2; j++)
        c[i][j] = DW'(seed * 256 + i * 2 + j);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_col(input string name, input col_t exp);
    checks++;
    if (red_column !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, red_column, exp);
    end
  endtask

  task automatic load_nominal();
    for (int i = 0; i < N_MATS; i++) red_sum[i] = DW'(nominal_sums[i]);
  endtask

  task automatic apply_stimulus(input int seed_a, input int seed_b);
    start = 1'b1;
    tick();
    start = 1'b0;
    col_valid = 1'b1;
    col_data = col_pattern(seed_a);
    tick();
    col_data = col_pattern(seed_b);
    tick();
    col_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, output int n);
    n = 0;
    while (!result_valid && n < 40) begin
      tick();
      n++;
    end
    check_output({name, " result_valid"}, result_valid, 1'b1);
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  initial begin
    // Nominal frame, one row per clock: inputs before the edge, expectations after it.
    vecs.push_back('{1'b1, 1'b0, 0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, 16'h0});
    vecs.push_back('{1'b0, 1'b1, 1, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,  1, -1, 16'h0});
    vecs.push_back('{1'b0, 1'b1, 2, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  2, -1, 16'h0});
    vecs.push_back('{1'b0, 1'b0, 0, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  2, -1, 16'h0});
    vecs.push_back('{1'b0, 1'b0, 0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 16'h0});
    for (int k = 0; k < 8; k++)
      vecs.push_back('{1'b0, 1'b0, 0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 16'h0});
    vecs.push_back('{1'b0, 1'b0, 0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 2, 16'd7});
    vecs.push_back('{1'b0, 1'b0, 0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 2, 16'd7});

    // Reset state
    tick();
    tick();
    check_output("reset col_ready", col_ready, 1'b0);
    check_output("reset red_valid_in", red_valid_in, 1'b0);
    check_output("reset result_valid", result_valid, 1'b0);
    check_output("reset busy", busy, 1'b0);
    check_output("reset wdog_err", wdog_err, 1'b0);
    check_output("reset class_idx", class_idx, 0);
    check_output("reset class_score", class_score, 0);
    rst = 1'b1;
    tick();

    // Nominal frame table
    load_nominal();
    rvi_count = 0;
    foreach (vecs[r]) begin
      start         = vecs[r].start;
      col_valid     = vecs[r].col_valid;
      col_data      = (vecs[r].col_seed > 0) ? col_pattern(vecs[r].col_seed) : '0;
      red_valid_out = vecs[r].rvo;
      result_ready  = vecs[r].rr;
      tick();
      check_output($sformatf("row%0d col_ready", r), col_ready, vecs[r].e_ready);
      check_output($sformatf("row%0d red_valid_in", r), red_valid_in, vecs[r].e_rvi);
      check_output($sformatf("row%0d result_valid", r), result_valid, vecs[r].e_rv);
      check_output($sformatf("row%0d busy", r), busy, vecs[r].e_busy);
      if (vecs[r].e_col > 0)
        check_col($sformatf("row%0d red_column", r), col_pattern(vecs[r].e_col));
      if (vecs[r].e_idx >= 0) begin
        check_output($sformatf("row%0d class_idx", r), class_idx, vecs[r].e_idx);
        check_output($sformatf("row%0d class_score", r), class_score, vecs[r].e_score);
      end
    end
    start = 1'b0; col_valid = 1'b0; red_valid_out = '0; result_ready = 1'b0;
    check_output("nominal strobe count", rvi_count, 2);

    // Column gaps, negative sums, result backpressure
    for (int i = 0; i < N_MATS; i++) red_sum[i] = DW'(-100);
    red_sum[9] = DW'(-3);
    rvi_count = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      col_valid = (k == 0 || k == 3);
      col_data  = col_pattern((k == 0) ? 3 : ((k == 3) ? 4 : 9));
      tick();
      check_output($sformatf("gap%0d red_valid_in", k), red_valid_in, (k == 0 || k == 3));
      check_output($sformatf("gap%0d col_ready", k), col_ready, (k < 3));
      check_col($sformatf("gap%0d red_column", k), col_pattern((k < 3) ? 3 : 4));
    end
    col_valid = 1'b0;
    red_valid_out = '1;
    tick();
    red_valid_out = '0;
    wait_result("negative", cycles);
    check_output("negative class_idx", class_idx, 9);
    check_output("negative class_score", class_score, 16'hFFFD);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_output($sformatf("hold%0d result_valid", k), result_valid, 1'b1);
      check_output($sformatf("hold%0d class_idx", k), class_idx, 9);
      check_output($sformatf("hold%0d class_score", k), class_score, 16'hFFFD);
    end
    handshake();
    check_output("post-handshake result_valid", result_valid, 1'b0);
    check_output("post-handshake busy", busy, 1'b0);
    check_output("gap strobe count", rvi_count, 2);

    // Staggered lane valids, lane 4 overwritten 10 -> 12
    for (int i = 0; i < N_MATS; i++) red_sum[i] = DW'((i < 4) ? i + 1 : i);
    red_sum[4] = DW'(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    col_valid = 1'b1; col_data = col_pattern(5); red_valid_out = 10'b00_0000_0111;
    tick();
    col_data = col_pattern(6); red_valid_out = 10'b00_0001_1000;
    tick();
    col_valid = 1'b0; red_valid_out = 10'b00_1110_0000;
    tick();
    red_valid_out = '0;
    tick();
    check_output("stagger waiting result_valid", result_valid, 1'b0);
    check_output("stagger waiting busy", busy, 1'b1);
    red_sum[4] = DW'(12);
    red_valid_out = 10'b11_0001_0000;
    tick();
    red_valid_out = '0;
    wait_result("stagger", cycles);
    check_output("stagger cycles to result", cycles, 10);
    check_output("stagger class_idx", class_idx, 4);
    check_output("stagger class_score", class_score, 12);
    handshake();

    // Asynchronous reset while draining
    apply_stimulus(7, 8);
    tick();
    #2 rst = 1'b0;
    #1;
    check_output("async col_ready", col_ready, 1'b0);
    check_output("async red_valid_in", red_valid_in, 1'b0);
    check_output("async result_valid", result_valid, 1'b0);
    check_output("async busy", busy, 1'b0);
    check_output("async class_idx", class_idx, 0);
    check_output("async class_score", class_score, 0);
    check_output("async wdog_err", wdog_err, 1'b0);
    check_col("async red_column", '0);
    #2 rst = 1'b1;
    load_nominal();
    apply_stimulus(1, 2);
    red_valid_out = '1;
    tick();
    red_valid_out = '0;
    wait_result("clean", cycles);
    check_output("clean class_idx", class_idx, 2);
    check_output("clean class_score", class_score, 7);
    handshake();
    check_output("clean idle busy", busy, 1'b0);

`ifdef REDUCTION_WATCHDOG_EN
    // Lane 3 never reports: watchdog aborts the frame
    rv_seen = 1'b0;
    apply_stimulus(1, 2);
    red_valid_out = 10'h3F7;
    cycles = 1;
    tick();
    red_valid_out = '0;
    while (busy && cycles < 40) begin
      tick();
      cycles++;
    end
    check_output("wdog drain cycles", cycles, 8);
    check_output("wdog_err set", wdog_err, 1'b1);
    check_output("wdog busy", busy, 1'b0);
    check_output("wdog no result", rv_seen, 1'b0);
    tick();
    check_output("wdog_err sticky", wdog_err, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reduction_sequencer.md
Name: reduction_sequencer

Overview:
- Controller for the decision-stage reduction array (N_MATS parallel 2-row reducers).
- Accepts a frame of N_COLS columns from the final conv/pool stage over a valid/ready handshake and issues them to the reducer array one column per beat.
- Collects the per-class sums and runs a serial signed argmax over them.
- Presents the winning class index and score on a valid/ready result port.

Parameters:
- N_MATS, 10, number of classes / parallel reducers.
- DATA_WIDTH, 16, signed width of column elements and sums.
- N_COLS, 2, columns per frame fed to each reducer.
- WDOG_CYCLES, 64, DRAIN-state timeout in cycles; used only with the watchdog feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; arms a new frame when in IDLE.
- col_valid  in  1  input column valid.
- col_ready  out  1  sequencer can accept a column.
- col_data  in  N_MATS x 2 x DATA_WIDTH  one column for each class matrix.
- red_valid_in  out  1  column strobe to reducer array.
- red_column  out  N_MATS x 2 x DATA_WIDTH  registered column to reducer array.
- red_valid_out  in  N_MATS  per-lane sum valid from reducer array.
- red_sum  in  N_MATS x DATA_WIDTH  per-lane sums from reducer array.
- result_valid  out  1  decision available.
- result_ready  in  1  consumer accepts decision.
- class_idx  out  $clog2(N_MATS)  argmax index.
- class_score  out  DATA_WIDTH  winning sum (signed).
- busy  out  1  high in any state other than IDLE.
- wdog_err  out  1  sticky watchdog flag; tied 0 when the feature is off.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All of col_ready, red_valid_in, result_valid, busy, wdog_err, class_idx, class_score, red_column, sum regs and lane mask clear to 0. Reset mid-frame discards the frame.
- IDLE:
  - start=1 → FEED, column counter cleared. start in any other state is ignored.
- FEED:
  - col_ready=1.
  - On col_valid & col_ready: col_data is registered into red_column and red_valid_in pulses on the next cycle (1-cycle latency). Counter increments.
  - When the N_COLS-th column is accepted → DRAIN; col_ready drops the same edge.
  - col_valid gaps are allowed; no column is ever dropped or duplicated.
- DRAIN:
  - col_ready=0.
  - For each lane with red_valid_out[i]=1, red_sum[i] is latched into sum_q[i] and mask[i] is set. A repeat pulse overwrites with the latest value.
  - Pulses arriving in FEED are also captured.
  - When the mask is all-ones → ARGMAX.
- ARGMAX:
  - Serial compare, one lane per cycle.
  - best is initialised to lane 0; lanes 1..N_MATS-1 are compared as signed.
  - Strictly greater replaces best, so ties keep the lower index.
  - Takes N_MATS-1 cycles, then → RESULT.
- RESULT:
  - result_valid=1 with class_idx/class_score stable.
  - When result_valid & result_ready: → IDLE, mask cleared, result_valid drops the next cycle.
  - Outputs hold while result_ready=0.
- N_MATS=1: ARGMAX takes 0 compare cycles and goes directly to RESULT with idx 0.
- Counter widths: $clog2(N_COLS+1); idx $clog2(N_MATS), minimum 1 bit.

Optional Feature:
- REDUCTION_WATCHDOG_EN defined:
  - A cycle counter runs in DRAIN.
  - If it reaches WDOG_CYCLES before the mask completes: wdog_err sets (sticky until reset) and state → IDLE with no result.
  - The counter clears on entering DRAIN.
- Not defined: no counter logic; wdog_err tied 0; DRAIN waits indefinitely.

Decomposition:
- Package decision_pkg holds:
  - the state enum (IDLE, FEED, DRAIN, ARGMAX, RESULT);
  - default constants N_MATS_DEF=10 and DATA_WIDTH_DEF=16;
  - a class-index width localparam function.
- One natural sub-module: argmax_serial (signed running max with lowest-index tie-break, start/done handshake), instantiated by reduction_sequencer.

Test Plan:
- Nominal frame: start, 2 columns fed back-to-back, reducer model returns sums {3,-1,7,2,0,5,7,-4,1,6} → class_idx=2, class_score=7 (tie with lane 6 resolved to the lower index); red_valid_in pulses exactly twice.
- Backpressure/gaps: col_valid toggling 1,0,0,1, and result_ready held low 5 cycles → columns issued in order; result held stable; IDLE reached one cycle after the handshake.
- Negative sums: all lanes -100 except lane 9 = -3 → class_idx=9, class_score=-3 (0xFFFD).
- Staggered valid_out: lanes assert valid over 4 different cycles, lane 4 twice (10 then 12) → ARGMAX starts only after the last lane; lane 4 uses 12.
- Async reset asserted in DRAIN → all outputs 0 immediately; a later start runs a clean frame.
- With REDUCTION_WATCHDOG_EN, WDOG_CYCLES=8, lane 3 never valid → wdog_err=1 after 8 DRAIN cycles, state IDLE, result_valid never asserted.
